fifo_uart_tx: RTL and testbench
===============================

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 Parameter DATA_WIDTH, default 8, bits per character.
REQ-002 Parameter CLKS_PER_BIT, default 868, clk cycles per serial bit; SHALL be >= 2.
REQ-003 Parameter PARITY, default 0: 0 = none, 1 = odd, 2 = even.
REQ-004 Parameter STOP_BITS, default 1, legal values 1 or 2.
REQ-005 clk  input  1  single clock; all state on posedge clk.
REQ-006 arst  input  1  asynchronous, active-high reset.
REQ-007 enable  input  1  high permits new characters to be popped.
REQ-008 empty  input  1  FIFO read-side empty flag; rData valid whenever empty is low.
REQ-009 rData  input  DATA_WIDTH  FIFO head word (first-word-fall-through).
REQ-010 rEn  output  1  pop strobe to FIFO; one word consumed per clk edge while high.
REQ-011 tx  output  1  serial line, idle high.
REQ-012 busy  output  1  high while a frame is in progress.
REQ-013 txDone  output  1  one-cycle pulse on the final cycle of each frame.

Function
REQ-014 FSM states IDLE, START, DATA, PARITY, STOP; busy SHALL be high in every state except IDLE.
REQ-015 rEn SHALL be combinational: enable & ~empty & ~arst & (state==IDLE | last cycle of last stop bit).
REQ-016 rEn SHALL never be high while empty is high (the FIFO does not guard underflow).
REQ-017 On a clk edge with rEn high, rData SHALL be captured into the shift register and the FSM SHALL enter START, with the bit counter cleared.
REQ-018 Each bit SHALL last exactly CLKS_PER_BIT cycles, timed by a counter of width $clog2(CLKS_PER_BIT).
REQ-019 START drives tx=0.
REQ-020 DATA shifts out DATA_WIDTH bits, LSB first.
REQ-021 PARITY (only when PARITY!=0) drives the XOR of the captured bits (even), or its inverse (odd).
REQ-022 STOP drives tx=1 for STOP_BITS bit periods.
REQ-023 Frame length SHALL be exactly (1+DATA_WIDTH+(PARITY!=0)+STOP_BITS)*CLKS_PER_BIT cycles.
REQ-024 tx SHALL be registered; it changes only on clk edges (except at reset).
REQ-025 Back-to-back: if rEn is high on the last stop-bit cycle, the next START SHALL begin on the following cycle with no idle gap.
REQ-026 Otherwise the FSM returns to IDLE with tx=1.
REQ-027 txDone SHALL be high exactly on the last cycle of the final stop bit, once per frame.
REQ-028 Deasserting enable mid-frame SHALL NOT abort the frame; the frame completes and no further pop occurs.
REQ-029 empty rising mid-frame SHALL have no effect on the current frame.
REQ-030 A character changing on rData after capture SHALL NOT affect the frame in progress.

Reset
REQ-031 While arst is high: state=IDLE, tx=1, busy=0, txDone=0, rEn=0, counters and shift register zero; effect immediate, independent of clk.
REQ-032 Reset asserted mid-frame SHALL abandon the frame (tx high at once) and SHALL NOT pop the FIFO; the popped character is lost.
REQ-033 After arst falls, the first pop SHALL occur on the first clk edge with enable & ~empty.

Verification
REQ-034 CLKS_PER_BIT=4, PARITY=0, STOP_BITS=1, one word 0xA5 -> rEn high one cycle; tx = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 cycles); txDone pulses in cycle 40; busy low afterwards.
REQ-035 Same configuration with PARITY=2, word 0xA5 -> parity bit 0; with PARITY=1 -> parity bit 1; frame 44 cycles.
REQ-036 FIFO holds 0x00 and 0xFF, enable=1 -> second start bit begins exactly 40 cycles after the first; rEn high exactly twice; no idle cycle between frames.
REQ-037 empty=1 held for 200 cycles with enable=1 -> rEn never high, tx constantly 1, busy 0.
REQ-038 arst pulsed during the DATA state -> tx=1 and busy=0 immediately; no rEn until empty=0 after reset release.
REQ-039 enable dropped in the START state of the first of two queued words -> that frame completes; rEn stays low; the second word remains in the FIFO.

Source files
------------

// File: rtl/fifo_uart_tx_if.sv
// FIFO read-side bundle between a first-word-fall-through FIFO and its consumer.
// The consumer (master) issues the pop strobe; the FIFO (slave) presents the
// head word and its empty flag.
interface fifo_uart_tx_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  empty;
   logic [DATA_WIDTH-1:0] rData;
   logic                  rEn;

   modport master (
      input  empty,
      input  rData,
      output rEn
   );

   modport slave (
      output empty,
      output rData,
      input  rEn
   );
endinterface

// File: rtl/fifo_uart_tx.sv
// UART transmitter fed from a first-word-fall-through FIFO.
// Frame: start bit, DATA_WIDTH data bits LSB first, optional parity bit, and
// STOP_BITS stop bits; every bit lasts CLKS_PER_BIT clocks. A new word may be
// popped on the last stop-bit cycle so consecutive frames run with no idle gap.
module fifo_uart_tx #(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 868,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic           clk,
   input  logic           arst,
   input  logic           enable,
   fifo_uart_tx_if.master fifo,
   output logic           tx,
   output logic           busy,
   output logic           txDone
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BW = $clog2(DATA_WIDTH + 1);

   localparam logic [CW-1:0] CNT_MAX   = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] DATA_LAST = BW'(DATA_WIDTH - 1);
   localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [BW-1:0]         bit_q, bit_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic                  par_q, par_d;
   logic                  tx_q, tx_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  cnt_last_s;
   logic                  last_stop_s;
   logic                  pop_s;

   // Parity of a character: even parity is the XOR of the bits, odd its inverse.
   function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] d);
      if (PARITY == 1) begin
         return ~(^d);
      end else begin
         return ^d;
      end
   endfunction

   // Pop decision: only when idle or on the very last stop-bit cycle, never in reset or on empty.
   always_comb begin
      cnt_last_s  = (cnt_q == CNT_MAX);
      last_stop_s = (state_q == S_STOP) && cnt_last_s && (bit_q == STOP_LAST);
      pop_s       = enable & ~fifo.empty & ~arst & ((state_q == S_IDLE) | last_stop_s);
   end

   assign fifo.rEn = pop_s;

   // Next-state logic: bit timing, bit sequencing and character capture on pop.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      par_d   = par_q;
      case (state_q)
         S_IDLE: begin
            if (pop_s) begin
               state_d = S_START;
               cnt_d   = {CW{1'b0}};
               bit_d   = {BW{1'b0}};
               shift_d = fifo.rData;
               par_d   = parity_bit(fifo.rData);
            end else begin
               state_d = S_IDLE;
            end
         end
         S_START: begin
            if (cnt_last_s) begin
               state_d = S_DATA;
               cnt_d   = {CW{1'b0}};
               bit_d   = {BW{1'b0}};
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DATA: begin
            if (cnt_last_s) begin
               cnt_d   = {CW{1'b0}};
               shift_d = shift_q >> 1;
               if (bit_q == DATA_LAST) begin
                  bit_d   = {BW{1'b0}};
                  state_d = (PARITY != 0) ? S_PARITY : S_STOP;
               end else begin
                  bit_d = bit_q + BW'(1);
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_PARITY: begin
            if (cnt_last_s) begin
               state_d = S_STOP;
               cnt_d   = {CW{1'b0}};
               bit_d   = {BW{1'b0}};
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_STOP: begin
            if (cnt_last_s) begin
               cnt_d = {CW{1'b0}};
               if (bit_q == STOP_LAST) begin
                  bit_d = {BW{1'b0}};
                  if (pop_s) begin
                     state_d = S_START;
                     shift_d = fifo.rData;
                     par_d   = parity_bit(fifo.rData);
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  bit_d = bit_q + BW'(1);
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = {CW{1'b0}};
            bit_d   = {BW{1'b0}};
         end
      endcase
   end

   // Output look-ahead: derive next tx/busy/txDone from the next state so outputs stay registered.
   always_comb begin
      tx_d = 1'b1;
      case (state_d)
         S_IDLE:   tx_d = 1'b1;
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = shift_d[0];
         S_PARITY: tx_d = par_d;
         S_STOP:   tx_d = 1'b1;
         default:  tx_d = 1'b1;
      endcase
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_STOP) && (cnt_d == CNT_MAX) && (bit_d == STOP_LAST);
   end

   // State and output registers; reset forces an idle, high line immediately.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_q <= S_IDLE;
         cnt_q   <= {CW{1'b0}};
         bit_q   <= {BW{1'b0}};
         shift_q <= {DATA_WIDTH{1'b0}};
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign tx     = tx_q;
   assign busy   = busy_q;
   assign txDone = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with CLKS_PER_BIT=4: dut0 has no parity,
// dut1 even parity, dut2 odd parity. Each DUT reads from a small bench FIFO.
module tb_fifo_uart_tx;

   logic clk = 1'b0;
   logic arst = 1'b0;
   logic enable = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   fifo_uart_tx_if #(.DATA_WIDTH(8)) if0 ();
   fifo_uart_tx_if #(.DATA_WIDTH(8)) if1 ();
   fifo_uart_tx_if #(.DATA_WIDTH(8)) if2 ();

   logic tx0, busy0, done0, tx1, busy1, done1, tx2, busy2, done2;

   fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1)) dut0 (
      .clk(clk), .arst(arst), .enable(enable), .fifo(if0), .tx(tx0), .busy(busy0), .txDone(done0));
   fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(1)) dut1 (
      .clk(clk), .arst(arst), .enable(enable), .fifo(if1), .tx(tx1), .busy(busy1), .txDone(done1));
   fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1)) dut2 (
      .clk(clk), .arst(arst), .enable(enable), .fifo(if2), .tx(tx2), .busy(busy2), .txDone(done2));

   // bench FIFOs (first-word-fall-through)
   logic [7:0] mem0 [16];
   logic [7:0] mem1 [16];
   logic [7:0] mem2 [16];
   int wp0 = 0, rp0 = 0, wp1 = 0, rp1 = 0, wp2 = 0, rp2 = 0;

   assign if0.empty = (wp0 == rp0);
   assign if1.empty = (wp1 == rp1);
   assign if2.empty = (wp2 == rp2);
   assign if0.rData = mem0[rp0[3:0]];
   assign if1.rData = mem1[rp1[3:0]];
   assign if2.rData = mem2[rp2[3:0]];

   always @(posedge clk) if (if0.rEn === 1'b1) rp0 <= rp0 + 1;
   always @(posedge clk) if (if1.rEn === 1'b1) rp1 <= rp1 + 1;
   always @(posedge clk) if (if2.rEn === 1'b1) rp2 <= rp2 + 1;

   // per-cycle observations, index 0 = first cycle after the pop edge
   logic c_tx   [3][200];
   logic c_busy [3][200];
   logic c_done [3][200];
   logic c_ren  [3][200];
   logic c_emp  [3][200];

   task automatic push(input int sel, input logic [7:0] d);
      case (sel)
         0: begin mem0[wp0[3:0]] = d; wp0 = wp0 + 1; end
         1: begin mem1[wp1[3:0]] = d; wp1 = wp1 + 1; end
         default: begin mem2[wp2[3:0]] = d; wp2 = wp2 + 1; end
      endcase
   endtask

   task automatic capture(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         #1;
         c_tx[0][k] = tx0;  c_busy[0][k] = busy0; c_done[0][k] = done0; c_ren[0][k] = if0.rEn; c_emp[0][k] = if0.empty;
         c_tx[1][k] = tx1;  c_busy[1][k] = busy1; c_done[1][k] = done1; c_ren[1][k] = if1.rEn; c_emp[1][k] = if1.empty;
         c_tx[2][k] = tx2;  c_busy[2][k] = busy2; c_done[2][k] = done2; c_ren[2][k] = if2.rEn; c_emp[2][k] = if2.empty;
      end
   endtask

   // Reference frame: bit 0 start, 1..8 data LSB first, optional parity, then stop.
   function automatic logic exp_bit(input logic [7:0] d, input int par, input int idx);
      if (idx == 0) return 1'b0;
      else if (idx <= 8) return d[idx-1];
      else if (par != 0 && idx == 9) return (par == 1) ? ~(^d) : (^d);
      else return 1'b1;
   endfunction

   task automatic test_reset();
      @(negedge clk);
      arst = 1'b1;
      enable = 1'b1;
      push(0, 8'h3C);
      repeat (3) @(negedge clk);
      #1;
      checks++; if (tx0 !== 1'b1) begin errors++; $display("FAIL reset_tx got %b expected 1", tx0); end
      checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy0); end
      checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", done0); end
      checks++; if (if0.rEn !== 1'b0) begin errors++; $display("FAIL reset_ren got %b expected 0", if0.rEn); end
      checks++; if (rp0 !== 0) begin errors++; $display("FAIL reset_nopop got %0d expected 0", rp0); end
      @(negedge clk);
      arst = 1'b0;
      #1;
      checks++; if (if0.rEn !== 1'b1) begin errors++; $display("FAIL reset_firstpop got %b expected 1", if0.rEn); end
      capture(42);
      for (int k = 0; k < 40; k++) begin
         checks++;
         if (c_tx[0][k] !== exp_bit(8'h3C, 0, k / 4)) begin
            errors++; $display("FAIL reset_frame_tx cycle %0d got %b expected %b", k, c_tx[0][k], exp_bit(8'h3C, 0, k / 4));
         end
      end
      checks++; if (c_busy[0][40] !== 1'b0) begin errors++; $display("FAIL reset_frame_end_busy got %b expected 0", c_busy[0][40]); end
   endtask

   task automatic test_single();
      logic [9:0] spec_vec;
      int nren;
      spec_vec = 10'b1101001010;
      nren = 0;
      @(negedge clk);
      push(0, 8'hA5);
      #1;
      checks++; if (if0.rEn !== 1'b1) begin errors++; $display("FAIL single_pop got %b expected 1", if0.rEn); end
      capture(44);
      for (int k = 0; k < 40; k++) begin
         checks++;
         if (c_tx[0][k] !== spec_vec[k / 4]) begin
            errors++; $display("FAIL single_tx cycle %0d got %b expected %b", k, c_tx[0][k], spec_vec[k / 4]);
         end
         checks++;
         if (c_done[0][k] !== (k == 39)) begin
            errors++; $display("FAIL single_done cycle %0d got %b expected %b", k, c_done[0][k], (k == 39));
         end
         checks++;
         if (c_busy[0][k] !== 1'b1) begin
            errors++; $display("FAIL single_busy cycle %0d got %b expected 1", k, c_busy[0][k]);
         end
      end
      for (int k = 0; k < 44; k++) if (c_ren[0][k] === 1'b1) nren++;
      checks++; if (nren !== 0) begin errors++; $display("FAIL single_extra_pop got %0d expected 0", nren); end
      checks++; if (c_busy[0][40] !== 1'b0) begin errors++; $display("FAIL single_end_busy got %b expected 0", c_busy[0][40]); end
      checks++; if (c_tx[0][40] !== 1'b1) begin errors++; $display("FAIL single_end_tx got %b expected 1", c_tx[0][40]); end
      checks++; if (c_done[0][40] !== 1'b0) begin errors++; $display("FAIL single_end_done got %b expected 0", c_done[0][40]); end
   endtask

   task automatic test_parity();
      @(negedge clk);
      push(1, 8'hA5);
      push(2, 8'hA5);
      #1;
      checks++; if (if1.rEn !== 1'b1) begin errors++; $display("FAIL parity_even_pop got %b expected 1", if1.rEn); end
      checks++; if (if2.rEn !== 1'b1) begin errors++; $display("FAIL parity_odd_pop got %b expected 1", if2.rEn); end
      capture(46);
      for (int s = 1; s < 3; s++) begin
         for (int k = 0; k < 44; k++) begin
            checks++;
            if (c_tx[s][k] !== exp_bit(8'hA5, (s == 1) ? 2 : 1, k / 4)) begin
               errors++; $display("FAIL parity_tx dut%0d cycle %0d got %b expected %b", s, k, c_tx[s][k], exp_bit(8'hA5, (s == 1) ? 2 : 1, k / 4));
            end
            checks++;
            if (c_done[s][k] !== (k == 43)) begin
               errors++; $display("FAIL parity_done dut%0d cycle %0d got %b expected %b", s, k, c_done[s][k], (k == 43));
            end
         end
         checks++; if (c_busy[s][44] !== 1'b0) begin errors++; $display("FAIL parity_end_busy dut%0d got %b expected 0", s, c_busy[s][44]); end
      end
      checks++; if (c_tx[1][37] !== 1'b0) begin errors++; $display("FAIL parity_even_bit got %b expected 0", c_tx[1][37]); end
      checks++; if (c_tx[2][37] !== 1'b1) begin errors++; $display("FAIL parity_odd_bit got %b expected 1", c_tx[2][37]); end
   endtask

   task automatic test_back_to_back();
      int nren;
      logic [7:0] d;
      nren = 0;
      @(negedge clk);
      push(0, 8'h00);
      push(0, 8'hFF);
      #1;
      checks++; if (if0.rEn !== 1'b1) begin errors++; $display("FAIL b2b_first_pop got %b expected 1", if0.rEn); end
      capture(84);
      for (int k = 0; k < 84; k++) begin
         if (c_ren[0][k] === 1'b1) nren++;
         if (c_ren[0][k] === 1'b1 && c_emp[0][k] === 1'b1) begin
            checks++; errors++; $display("FAIL b2b_underflow cycle %0d got rEn 1 expected 0", k);
         end
      end
      checks++; if (nren !== 1) begin errors++; $display("FAIL b2b_pop_count got %0d expected 1", nren); end
      checks++; if (c_ren[0][39] !== 1'b1) begin errors++; $display("FAIL b2b_second_pop got %b expected 1", c_ren[0][39]); end
      for (int k = 0; k < 80; k++) begin
         d = (k < 40) ? 8'h00 : 8'hFF;
         checks++;
         if (c_tx[0][k] !== exp_bit(d, 0, (k % 40) / 4)) begin
            errors++; $display("FAIL b2b_tx cycle %0d got %b expected %b", k, c_tx[0][k], exp_bit(d, 0, (k % 40) / 4));
         end
         checks++;
         if (c_busy[0][k] !== 1'b1) begin errors++; $display("FAIL b2b_busy cycle %0d got %b expected 1", k, c_busy[0][k]); end
         checks++;
         if (c_done[0][k] !== (k == 39 || k == 79)) begin
            errors++; $display("FAIL b2b_done cycle %0d got %b expected %b", k, c_done[0][k], (k == 39 || k == 79));
         end
      end
      checks++; if (c_busy[0][80] !== 1'b0) begin errors++; $display("FAIL b2b_end_busy got %b expected 0", c_busy[0][80]); end
      checks++; if (rp0 !== wp0) begin errors++; $display("FAIL b2b_drained got %0d expected %0d", rp0, wp0); end
   endtask

   task automatic test_empty_idle();
      int nren, ntx, nbusy;
      nren = 0; ntx = 0; nbusy = 0;
      enable = 1'b1;
      capture(200);
      for (int k = 0; k < 200; k++) begin
         if (c_ren[0][k] !== 1'b0) nren++;
         if (c_tx[0][k] !== 1'b1) ntx++;
         if (c_busy[0][k] !== 1'b0) nbusy++;
      end
      checks++; if (nren !== 0) begin errors++; $display("FAIL empty_ren got %0d cycles expected 0", nren); end
      checks++; if (ntx !== 0) begin errors++; $display("FAIL empty_tx_low got %0d cycles expected 0", ntx); end
      checks++; if (nbusy !== 0) begin errors++; $display("FAIL empty_busy got %0d cycles expected 0", nbusy); end
   endtask

   task automatic test_arst_mid();
      int saved;
      @(negedge clk);
      push(0, 8'h5A);
      capture(12);
      checks++; if (tx0 !== exp_bit(8'h5A, 0, 2)) begin errors++; $display("FAIL arst_pre_tx got %b expected %b", tx0, exp_bit(8'h5A, 0, 2)); end
      arst = 1'b1;
      #1;
      checks++; if (tx0 !== 1'b1) begin errors++; $display("FAIL arst_tx got %b expected 1", tx0); end
      checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL arst_busy got %b expected 0", busy0); end
      push(0, 8'hC3);
      #1;
      checks++; if (if0.rEn !== 1'b0) begin errors++; $display("FAIL arst_ren got %b expected 0", if0.rEn); end
      saved = rp0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (rp0 !== saved) begin errors++; $display("FAIL arst_nopop got %0d expected %0d", rp0, saved); end
      @(negedge clk);
      arst = 1'b0;
      #1;
      checks++; if (if0.rEn !== 1'b1) begin errors++; $display("FAIL arst_release_pop got %b expected 1", if0.rEn); end
      capture(42);
      for (int k = 0; k < 40; k++) begin
         checks++;
         if (c_tx[0][k] !== exp_bit(8'hC3, 0, k / 4)) begin
            errors++; $display("FAIL arst_frame_tx cycle %0d got %b expected %b", k, c_tx[0][k], exp_bit(8'hC3, 0, k / 4));
         end
      end
      checks++; if (c_done[0][39] !== 1'b1) begin errors++; $display("FAIL arst_frame_done got %b expected 1", c_done[0][39]); end
      checks++; if (c_busy[0][40] !== 1'b0) begin errors++; $display("FAIL arst_frame_end got %b expected 0", c_busy[0][40]); end
   endtask

   task automatic test_enable_drop();
      int nren;
      nren = 0;
      @(negedge clk);
      push(0, 8'h12);
      push(0, 8'h34);
      #1;
      checks++; if (if0.rEn !== 1'b1) begin errors++; $display("FAIL endrop_pop got %b expected 1", if0.rEn); end
      @(posedge clk);
      #1;
      enable = 1'b0;
      capture(44);
      for (int k = 0; k < 44; k++) if (c_ren[0][k] === 1'b1) nren++;
      for (int k = 0; k < 40; k++) begin
         checks++;
         if (c_tx[0][k] !== exp_bit(8'h12, 0, k / 4)) begin
            errors++; $display("FAIL endrop_tx cycle %0d got %b expected %b", k, c_tx[0][k], exp_bit(8'h12, 0, k / 4));
         end
      end
      checks++; if (c_done[0][39] !== 1'b1) begin errors++; $display("FAIL endrop_done got %b expected 1", c_done[0][39]); end
      checks++; if (c_busy[0][40] !== 1'b0) begin errors++; $display("FAIL endrop_end_busy got %b expected 0", c_busy[0][40]); end
      checks++; if (nren !== 0) begin errors++; $display("FAIL endrop_ren got %0d expected 0", nren); end
      checks++; if (wp0 - rp0 !== 1) begin errors++; $display("FAIL endrop_left got %0d expected 1", wp0 - rp0); end
      @(negedge clk);
      enable = 1'b1;
      #1;
      checks++; if (if0.rEn !== 1'b1) begin errors++; $display("FAIL endrop_resume_pop got %b expected 1", if0.rEn); end
      capture(42);
      for (int k = 0; k < 40; k++) begin
         checks++;
         if (c_tx[0][k] !== exp_bit(8'h34, 0, k / 4)) begin
            errors++; $display("FAIL endrop_second_tx cycle %0d got %b expected %b", k, c_tx[0][k], exp_bit(8'h34, 0, k / 4));
         end
      end
      checks++; if (c_busy[0][40] !== 1'b0) begin errors++; $display("FAIL endrop_second_end got %b expected 0", c_busy[0][40]); end
   endtask

   initial begin
      #2;
      arst = 1'b1;
      test_reset();
      test_single();
      test_parity();
      test_back_to_back();
      test_empty_idle();
      test_arst_mid();
      test_enable_drop();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
